// File: rtl/lcd_frame_fetch_ctrl_if.sv
// Memory burst request/response and LCD FIFO write port bundle.
// master = fetch controller, slave = memory system plus FIFO.
interface lcd_frame_fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LEN_W-1:0]  mem_req_len;
    logic              mem_rsp_valid;
    logic              mem_rsp_ready;
    logic [15:0]       mem_rsp_data;
    logic              mem_rsp_err;
    logic              fifo_wr_en;
    logic              fifo_wr_vld;
    logic [15:0]       fifo_wr_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_len,
        output mem_rsp_ready, fifo_wr_en, fifo_wr_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  mem_rsp_err, fifo_wr_vld
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_len,
        input  mem_rsp_ready, fifo_wr_en, fifo_wr_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output mem_rsp_err, fifo_wr_vld
    );
endinterface

// File: rtl/lcd_frame_fetch_ctrl.sv
// LCD frame fetch: bursts frame-buffer reads into the prefetch FIFO.
// LCD_FETCH_PERF_CNT_EN adds stall_cnt/frame_cnt performance counters.
module lcd_frame_fetch_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int PIX_W     = 20,
    parameter int BURST_LEN = 16,
    parameter int LEN_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_en,
    input  logic              ctrl_cont,
    input  logic [ADDR_W-1:0] ctrl_base,
    input  logic [PIX_W-1:0]  ctrl_pix_num,
    output logic              busy,
    output logic              frame_done,
    output logic              err_flag,
`ifdef LCD_FETCH_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [15:0]       frame_cnt,
`endif
    lcd_frame_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_FEND
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beats_left;
    logic [PIX_W-1:0]  r_total;
    logic [PIX_W-1:0]  r_pix_done;
    logic              r_err;

    logic              w_start;
    logic              w_load;
    logic              w_hs;
    logic              w_beat;
    logic              w_last;
    logic              w_frame_end;
    logic              w_next_req;
    logic [PIX_W-1:0]  w_rem;

    function automatic logic [LEN_W-1:0] f_len(
        input logic [PIX_W-1:0] rem
    );
        if (rem >= PIX_W'(BURST_LEN))
            return LEN_W'(BURST_LEN);
        return rem[LEN_W-1:0];
    endfunction

    assign w_start = (r_state == S_IDLE) && ctrl_en
                  && (ctrl_pix_num != '0);
    assign w_load  = w_start
                  || ((r_state == S_FEND) && ctrl_en && ctrl_cont
                      && (ctrl_pix_num != '0));
    assign w_hs    = (r_state == S_REQ) && bus.mem_req_ready;
    assign w_beat  = (r_state == S_DATA) && bus.mem_rsp_valid
                  && bus.fifo_wr_vld;
    assign w_last  = w_beat && (r_beats_left == LEN_W'(1));
    assign w_frame_end = (r_pix_done + PIX_W'(1)) == r_total;
    assign w_next_req  = w_last && !w_frame_end && ctrl_en;
    assign w_rem       = r_total - r_pix_done - PIX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_REQ;
            S_REQ: begin
                // An accepted request is never dropped, even if en fell.
                if (w_hs)
                    w_state_nxt = S_DATA;
                else if (!ctrl_en)
                    w_state_nxt = S_IDLE;
            end
            S_DATA: begin
                if (w_last) begin
                    if (w_frame_end)
                        w_state_nxt = S_FEND;
                    else if (ctrl_en)
                        w_state_nxt = S_REQ;
                    else
                        w_state_nxt = S_IDLE;
                end
            end
            S_FEND: w_state_nxt = w_load ? S_REQ : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_addr tracks base + 2*pix_done of the next burst to request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_len        <= '0;
            r_beats_left <= '0;
            r_total      <= '0;
            r_pix_done   <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_load) begin
                r_addr     <= ctrl_base & ~ADDR_W'(1);
                r_len      <= f_len(ctrl_pix_num);
                r_total    <= ctrl_pix_num;
                r_pix_done <= '0;
            end
            if (w_hs) begin
                r_beats_left <= r_len;
                r_addr <= r_addr + ADDR_W'({r_len, 1'b0});
            end
            if (w_beat) begin
                r_beats_left <= r_beats_left - LEN_W'(1);
                r_pix_done   <= r_pix_done + PIX_W'(1);
            end
            if (w_next_req)
                r_len <= f_len(w_rem);
            if (w_start)
                r_err <= 1'b0;
            else if (w_beat && bus.mem_rsp_err)
                r_err <= 1'b1;
        end
    end

`ifdef LCD_FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_frame_cnt <= '0;
        end else if (w_start) begin
            r_stall_cnt <= '0;
            r_frame_cnt <= '0;
        end else begin
            if ((r_state == S_DATA) && bus.mem_rsp_valid
                && !bus.fifo_wr_vld)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (r_state == S_FEND)
                r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign frame_cnt = r_frame_cnt;
`endif

    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_FEND);
    assign err_flag   = r_err;

    assign bus.mem_req_valid = (r_state == S_REQ);
    assign bus.mem_req_addr  = r_addr;
    assign bus.mem_req_len   = r_len;
    assign bus.mem_rsp_ready = (r_state == S_DATA) && bus.fifo_wr_vld;
    assign bus.fifo_wr_en    = w_beat;
    assign bus.fifo_wr_data  = bus.mem_rsp_data;

endmodule

// File: tb/tb_lcd_frame_fetch_ctrl.sv
// Scoreboard bench for lcd_frame_fetch_ctrl.
// Memory model answers bursts; monitor pops expected requests/pixels.
module tb_lcd_frame_fetch_ctrl;
    localparam int ADDR_W = 32;
    localparam int PIX_W  = 20;
    localparam int BLEN   = 16;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ctrl_en = 1'b0;
    logic              ctrl_cont = 1'b0;
    logic [ADDR_W-1:0] ctrl_base = '0;
    logic [PIX_W-1:0]  ctrl_pix_num = '0;
    logic              busy;
    logic              frame_done;
    logic              err_flag;
`ifdef LCD_FETCH_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [15:0]       frame_cnt;
`endif

    lcd_frame_fetch_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bif ();

    lcd_frame_fetch_ctrl #(
        .ADDR_W(ADDR_W), .PIX_W(PIX_W),
        .BURST_LEN(BLEN), .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ctrl_en(ctrl_en),
        .ctrl_cont(ctrl_cont),
        .ctrl_base(ctrl_base),
        .ctrl_pix_num(ctrl_pix_num),
        .busy(busy),
        .frame_done(frame_done),
        .err_flag(err_flag),
`ifdef LCD_FETCH_PERF_CNT_EN
        .stall_cnt(stall_cnt),
        .frame_cnt(frame_cnt),
`endif
        .bus(bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [ADDR_W+LEN_W-1:0] exp_req[$];
    logic [15:0] exp_pix[$];
    int frames_seen = 0;
    int reqs_seen = 0;
    int stall_obs = 0;
    int beats_total = 0;
    int stall_at = -1;
    int stall_left = 0;
    int err_at = -1;
    bit mem_flush = 1'b0;

    function automatic logic [15:0] pix_of(logic [31:0] a);
        return a[16:1] ^ 16'hA5C3;
    endfunction

    task automatic check(string name, logic [63:0] act,
                         logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic push_frame(logic [31:0] base, int n);
        for (int off = 0; off < n; off += BLEN) begin
            int l;
            l = (n - off > BLEN) ? BLEN : n - off;
            exp_req.push_back({base + 32'(2 * off), LEN_W'(l)});
        end
        for (int i = 0; i < n; i++)
            exp_pix.push_back(pix_of(base + 32'(2 * i)));
    endtask

    task automatic wait_frames(int target, int bound);
        int k;
        k = 0;
        while (frames_seen < target && k < bound) begin
            tick();
            k++;
        end
        check("frame_wait", 64'(frames_seen >= target), 64'd1);
    endtask

    task automatic wait_idle(int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            tick();
            k++;
        end
        check("idle_wait", 64'(busy), 64'd0);
    endtask

    // Memory + FIFO model: drives at negedge, samples fires at +1.
    initial begin : mem_model
        logic [31:0] m_addr, q_addr;
        int rem, idx, q_len;
        bit rf, qf, vld;
        m_addr = '0; q_addr = '0;
        rem = 0; idx = 0; q_len = 0;
        rf = 0; qf = 0;
        bif.mem_req_ready = 1'b1;
        bif.mem_rsp_valid = 1'b0;
        bif.mem_rsp_data  = '0;
        bif.mem_rsp_err   = 1'b0;
        bif.fifo_wr_vld   = 1'b1;
        forever begin
            @(negedge clk);
            if (rf) begin
                rem--; idx++; beats_total++;
            end
            if (qf) begin
                m_addr = q_addr; rem = q_len; idx = 0;
            end
            if (mem_flush) begin
                rem = 0; mem_flush = 1'b0;
            end
            vld = 1'b1;
            if (stall_left > 0 && rem > 0
                && beats_total == stall_at) begin
                vld = 1'b0;
                stall_left--;
            end
            bif.fifo_wr_vld   = vld;
            bif.mem_rsp_valid = (rem > 0);
            bif.mem_rsp_data  = pix_of(m_addr + 32'(2 * idx));
            bif.mem_rsp_err   = (rem > 0) && (beats_total == err_at);
            #1;
            rf = bif.mem_rsp_valid && bif.mem_rsp_ready;
            qf = bif.mem_req_valid && bif.mem_req_ready;
            if (qf) begin
                q_addr = bif.mem_req_addr;
                q_len  = int'(bif.mem_req_len);
            end
            if (!vld && rem > 0) begin
                stall_obs++;
                check("rsp_ready_stall", 64'(bif.mem_rsp_ready), 64'd0);
                check("wr_en_stall", 64'(bif.fifo_wr_en), 64'd0);
            end
        end
    end

    initial begin : monitor
        logic [ADDR_W+LEN_W-1:0] er;
        logic [15:0] ep;
        forever begin
            @(negedge clk);
            #2;
            if (bif.fifo_wr_en) begin
                if (exp_pix.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write actual=%0h required=none",
                             bif.fifo_wr_data);
                end else begin
                    ep = exp_pix.pop_front();
                    check("fifo_wr_data", 64'(bif.fifo_wr_data), 64'(ep));
                end
            end
            if (bif.mem_req_valid && bif.mem_req_ready) begin
                reqs_seen++;
                if (exp_req.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_req actual=%0h/%0d required=none",
                             bif.mem_req_addr, bif.mem_req_len);
                end else begin
                    er = exp_req.pop_front();
                    check("mem_req_addr_len",
                          64'({bif.mem_req_addr, bif.mem_req_len}),
                          64'(er));
                end
            end
            if (frame_done) frames_seen++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int f0, r0, k;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 0);
        check("rst_frame_done", 64'(frame_done), 0);
        check("rst_err", 64'(err_flag), 0);
        check("rst_req_valid", 64'(bif.mem_req_valid), 0);
        check("rst_req_addr", 64'(bif.mem_req_addr), 0);
        check("rst_req_len", 64'(bif.mem_req_len), 0);
        check("rst_rsp_ready", 64'(bif.mem_rsp_ready), 0);
        check("rst_wr_en", 64'(bif.fifo_wr_en), 0);
        rst_n = 1'b1;
        tick();

        // single frame, 40 pixels
        ctrl_base = 32'h8000_0000; ctrl_pix_num = 20'd40;
        ctrl_cont = 1'b0;
        push_frame(32'h8000_0000, 40);
        f0 = frames_seen;
        ctrl_en = 1'b1;
        tick();
        check("req_valid_cycle1", 64'(bif.mem_req_valid), 1);
        check("busy_cycle1", 64'(busy), 1);
        wait_frames(f0 + 1, 200);
        ctrl_en = 1'b0;
        wait_idle(20);
        repeat (3) tick();
        check("t1_frames", 64'(frames_seen), 64'(f0 + 1));
        check("t1_pix_left", 64'(exp_pix.size()), 0);
        check("t1_req_left", 64'(exp_req.size()), 0);

        // continuous mode, base changed during frame 3
        ctrl_pix_num = 20'd16; ctrl_cont = 1'b1;
        for (int i = 0; i < 3; i++) push_frame(32'h8000_0000, 16);
        push_frame(32'h9000_0000, 16);
        f0 = frames_seen;
        ctrl_en = 1'b1;
        wait_frames(f0 + 2, 200);
        repeat (5) tick();
        ctrl_base = 32'h9000_0000;
        wait_frames(f0 + 4, 200);
        ctrl_en = 1'b0; ctrl_cont = 1'b0;
        wait_idle(20);
        check("t2_pix_left", 64'(exp_pix.size()), 0);
        check("t2_req_left", 64'(exp_req.size()), 0);

        // FIFO stall of 5 cycles mid-burst
        ctrl_base = 32'h8000_1000; ctrl_pix_num = 20'd32;
        push_frame(32'h8000_1000, 32);
        stall_obs = 0;
        stall_at = beats_total + 20;
        stall_left = 5;
        f0 = frames_seen;
        ctrl_en = 1'b1;
        wait_frames(f0 + 1, 200);
        ctrl_en = 1'b0;
        wait_idle(20);
        check("t3_stall_cycles", 64'(stall_obs), 5);
        check("t3_pix_left", 64'(exp_pix.size()), 0);
`ifdef LCD_FETCH_PERF_CNT_EN
        check("t3_stall_cnt", 64'(stall_cnt), 5);
        check("t3_frame_cnt", 64'(frame_cnt), 1);
`endif

        // en dropped after burst 2 of 3 handshakes
        ctrl_base = 32'h8000_2000; ctrl_pix_num = 20'd48;
        push_frame(32'h8000_2000, 32);
        f0 = frames_seen; r0 = reqs_seen;
        ctrl_en = 1'b1;
        k = 0;
        while (reqs_seen < r0 + 2 && k < 200) begin
            tick(); k++;
        end
        check("t4_req2_seen", 64'(reqs_seen), 64'(r0 + 2));
        tick();
        ctrl_en = 1'b0;
        wait_idle(100);
        repeat (3) tick();
        check("t4_no_frame_done", 64'(frames_seen), 64'(f0));
        check("t4_reqs", 64'(reqs_seen), 64'(r0 + 2));
        check("t4_pix_left", 64'(exp_pix.size()), 0);

        // error on beat 3
        ctrl_base = 32'h8000_3000; ctrl_pix_num = 20'd16;
        push_frame(32'h8000_3000, 16);
        err_at = beats_total + 3;
        f0 = frames_seen;
        ctrl_en = 1'b1;
        tick();
        check("t5_err_clear", 64'(err_flag), 0);
        wait_frames(f0 + 1, 200);
        ctrl_en = 1'b0;
        err_at = -1;
        wait_idle(20);
        check("t5_err_held", 64'(err_flag), 1);
        check("t5_pix_left", 64'(exp_pix.size()), 0);

        // zero pixel count never starts
        r0 = reqs_seen;
        ctrl_pix_num = '0;
        ctrl_en = 1'b1;
        repeat (5) tick();
        check("t6_busy", 64'(busy), 0);
        check("t6_no_req", 64'(reqs_seen), 64'(r0));
        check("t6_err_still", 64'(err_flag), 1);
        ctrl_en = 1'b0;
        tick();

        // restart clears err; reset mid-DATA
        ctrl_base = 32'h8000_4000; ctrl_pix_num = 20'd64;
        push_frame(32'h8000_4000, 16);
        ctrl_en = 1'b1;
        tick();
        check("t7_err_cleared", 64'(err_flag), 0);
        check("t7_req_valid", 64'(bif.mem_req_valid), 1);
        repeat (6) tick();
        check("t7_in_data", 64'(bif.mem_rsp_ready), 1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_busy", 64'(busy), 0);
        check("t7_rst_req_valid", 64'(bif.mem_req_valid), 0);
        check("t7_rst_req_addr", 64'(bif.mem_req_addr), 0);
        check("t7_rst_req_len", 64'(bif.mem_req_len), 0);
        check("t7_rst_rsp_ready", 64'(bif.mem_rsp_ready), 0);
        check("t7_rst_wr_en", 64'(bif.fifo_wr_en), 0);
        check("t7_rst_frame_done", 64'(frame_done), 0);
        ctrl_en = 1'b0;
        exp_pix.delete();
        exp_req.delete();
        mem_flush = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t7_idle_after", 64'(busy), 0);
`ifdef LCD_FETCH_PERF_CNT_EN
        check("t7_stall_cnt_rst", 64'(stall_cnt), 0);
        check("t7_frame_cnt_rst", 64'(frame_cnt), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_frame_fetch_ctrl.md
# lcd_frame_fetch_ctrl

Fetches one LCD frame of 16-bit RGB565 pixels from the frame buffer in fixed-length read bursts and pushes the returned beats into the write port of the LCD prefetch FIFO. It sits on the system-clock side of the FIFO. It sequences the bursts and walks the frame address, and it converts FIFO not-full status into response back-pressure so the FIFO never overflows. Single-frame and continuous (auto-restart) modes are supported.

## Interface
- ADDR_W, 32, byte address width
- PIX_W, 20, width of pixel-count fields
- BURST_LEN, 16, maximum beats per burst (power of 2, 1..128)
- LEN_W, 8, width of mem_req_len
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ctrl_en  in  1  level; 1 = run, 0 = stop after the current burst
- ctrl_cont  in  1  1 = restart automatically at end of frame
- ctrl_base  in  ADDR_W  frame base byte address (bit 0 ignored)
- ctrl_pix_num  in  PIX_W  pixels per frame
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a frame completes
- err_flag  out  1  sticky; set by mem_rsp_err
- mem_req_valid  out  1  burst request valid
- mem_req_ready  in  1  burst request accepted
- mem_req_addr  out  ADDR_W  burst start byte address
- mem_req_len  out  LEN_W  beats in burst (1..BURST_LEN)
- mem_rsp_valid  in  1  response beat valid
- mem_rsp_ready  out  1  response beat accepted
- mem_rsp_data  in  16  response pixel
- mem_rsp_err  in  1  beat error, qualified by mem_rsp_valid
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_vld  in  1  FIFO can accept a write
- fifo_wr_data  out  16  FIFO write data

## Operation
- States: IDLE, REQ, DATA, FEND.
- IDLE: if ctrl_en=1 and ctrl_pix_num≠0, latch ctrl_base into base_q and ctrl_pix_num into total_q, clear pix_done, then go to REQ. If ctrl_pix_num=0, stay in IDLE and issue nothing.
- REQ: mem_req_valid=1, mem_req_addr=base_q+2·pix_done, mem_req_len=min(BURST_LEN, total_q−pix_done). Address and length stay stable until mem_req_ready. On the handshake, latch beats_left=mem_req_len and go to DATA.
- DATA: mem_rsp_ready=fifo_wr_vld. fifo_wr_en=mem_rsp_valid & fifo_wr_vld and fifo_wr_data=mem_rsp_data (combinational pass-through). Each accepted beat decrements beats_left and increments pix_done. On the last beat:
  - pix_done reaches total_q → FEND
  - else ctrl_en=1 → REQ
  - else → IDLE
- FEND: frame_done=1 for one cycle. If ctrl_en & ctrl_cont, relatch ctrl_base and ctrl_pix_num (if ctrl_pix_num=0, go to IDLE instead), clear pix_done, go to REQ. Otherwise go to IDLE.
- At most one burst is outstanding. A burst is never abandoned: dropping ctrl_en in REQ before the handshake returns to IDLE next cycle with no request issued. Dropping it in DATA completes all remaining beats first.
- mem_rsp_err: the beat is still counted and written. err_flag is set and held until the next IDLE→REQ transition.
- Beats arriving outside DATA are not accepted (mem_rsp_ready=0).
- Arithmetic: address arithmetic is modulo 2^ADDR_W and wraps silently. pix_done is PIX_W bits and never exceeds total_q.

## Timing
- Reset values: state=IDLE, busy=0, frame_done=0, err_flag=0, mem_req_valid=0, mem_req_addr=0, mem_req_len=0, mem_rsp_ready=0, fifo_wr_en=0, pix_done=0.
- ctrl_en rises at cycle 0 → mem_req_valid=1 at cycle 1. All request outputs are registered.
- Request handshake at cycle n → mem_rsp_ready may assert at n+1.
- Last beat at cycle m → next mem_req_valid at m+1, or frame_done at m+1.
- Back-to-back beats are accepted at one per cycle while fifo_wr_vld=1. Zero extra latency from a beat to fifo_wr_en.
- fifo_wr_vld=0 with mem_rsp_valid=1 stalls the beat, with no write and no count.
- Asserting rst_n=0 mid-burst aborts immediately to the reset values. Responses still in flight from the memory system are the system's concern.

## Configuration
- LCD_FETCH_PERF_CNT_EN defined: adds outputs stall_cnt[31:0] and frame_cnt[15:0].
  - stall_cnt counts cycles with mem_rsp_valid & ~fifo_wr_vld in DATA.
  - frame_cnt counts frame_done pulses.
  - Both reset to 0, wrap silently, and clear on the IDLE→REQ transition.
- LCD_FETCH_PERF_CNT_EN not defined: the ports and logic are absent, and behaviour is otherwise identical.

## Test plan
- Base 0x8000_0000, pix_num 40, BURST_LEN 16, ctrl_cont=0, memory always ready, FIFO always vld → requests (0x8000_0000,16), (0x8000_0020,16), (0x8000_0040,8); 40 fifo_wr_en with data matching; one frame_done; return to IDLE, busy=0.
- ctrl_cont=1, pix_num 16, hold ctrl_en → back-to-back frames, each request at 0x8000_0000 len 16, frame_done every frame. Change ctrl_base mid-frame → the new base is applied only at the next frame.
- fifo_wr_vld toggled 0 for 5 cycles mid-burst → mem_rsp_ready=0 during the stall, no beats lost or duplicated. With the macro defined, stall_cnt=5.
- ctrl_en dropped after the handshake of burst 2 of 3 → burst 2 completes all 16 beats, no third request, frame_done=0, IDLE.
- mem_rsp_err on beat 3 → beat written, err_flag=1 held until the next start, frame still completes.
- pix_num 0 with ctrl_en=1 → no request, busy=0. Reset asserted mid-DATA → all outputs return to reset values on the next edge.
